// File: rtl/oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl - sprite DMA sequencer at CPU address $4014.
//
// A CPU write of page P to $4014 stalls the CPU and copies bus bytes
// $PP00-$PPFF into OAM. Each byte costs one READ cycle on the CPU bus and
// one OAMDATA ($2004) WRITE cycle on the PPU register port.
//
// Build option:
//   OAM_DMA_ALIGN_EN  defined   -> a one-cycle ALIGN state is inserted after
//                                  the dummy cycle when needed, so every READ
//                                  falls on a phase=0 cycle (513 or 514
//                                  halted cycles per transfer).
//                     undefined -> HALT always exits straight to READ and no
//                                  phase is tracked (513 halted cycles).
//
// All outputs are decoded from registered state only; no input reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [2:0]  OAMDATA_REG  = 3'd4,
    parameter int          XFER_LEN     = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_WE,
    input  logic        cpu_is_read,
    output logic        cpu_halt,
    output logic        dma_busy,
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    input  logic [7:0]  mem_data_in,
    output logic        ppu_cs_n,
    output logic [2:0]  ppu_reg_addr,
    output logic        ppu_WE,
    output logic [7:0]  ppu_data
);

    // Offset of the final byte of a transfer; the offset counter is 8 bits,
    // so the transfer can never leave the latched page.
    localparam logic [7:0] LAST_OFFSET = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [7:0]  page_reg;
    logic [7:0]  page_next;
    logic [7:0]  offset_reg;
    logic [7:0]  offset_next;
    logic [7:0]  data_lat_reg;
    logic [7:0]  data_lat_next;

    // A trigger is only honoured from IDLE; writes to $4014 while a transfer
    // is running (and writes to any other address) fall through untouched.
    logic        trigger_hit;
    assign trigger_hit = cpu_WE && (cpu_addr == DMA_REG_ADDR);

    // The HALT state can only hand over to the DMA once the CPU is sitting
    // in a read cycle: RDY cannot stall a write.
    logic        dummy_cycle;
    assign dummy_cycle = cpu_is_read;

`ifdef OAM_DMA_ALIGN_EN
    // Bus phase: toggles every cycle, cleared by reset. READ cycles are only
    // allowed while this is 0.
    logic        phase_reg;

    // Free-running phase toggle.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_reg <= 1'b0;
        end else begin
            phase_reg <= ~phase_reg;
        end
    end

    // The cycle after the dummy cycle has phase ~phase_reg. If that is 0 we
    // can read immediately, otherwise burn one ALIGN cycle first.
    logic        read_phase_ok;
    assign read_phase_ok = phase_reg;
`else
    // Without alignment the first READ always follows the dummy cycle.
    logic        read_phase_ok;
    assign read_phase_ok = 1'b1;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            page_reg     <= 8'h00;
            offset_reg   <= 8'h00;
            data_lat_reg <= 8'h00;
        end else begin
            state_reg    <= state_next;
            page_reg     <= page_next;
            offset_reg   <= offset_next;
            data_lat_reg <= data_lat_next;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_next    = state_reg;
        page_next     = page_reg;
        offset_next   = offset_reg;
        data_lat_next = data_lat_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (trigger_hit) begin
                    page_next   = cpu_data_in;
                    offset_next = 8'h00;
                    state_next  = ST_HALT;
                end
            end

            ST_HALT: begin
                // Stay here through CPU write cycles; the first read cycle
                // is the dummy cycle and ends the wait.
                if (dummy_cycle) begin
                    state_next = read_phase_ok ? ST_READ : ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                state_next = ST_READ;
            end

            ST_READ: begin
                // Bus data is valid at the edge that closes the read.
                data_lat_next = mem_data_in;
                state_next    = ST_WRITE;
            end

            ST_WRITE: begin
                // OAMADDR auto-increments inside the PPU; we only track the
                // source offset.
                offset_next = offset_reg + 8'd1;
                state_next  = (offset_reg == LAST_OFFSET) ? ST_IDLE : ST_READ;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Moore output decode from the registered state.
    always_comb begin
        cpu_halt     = 1'b0;
        dma_busy     = 1'b0;
        dma_rd       = 1'b0;
        dma_addr     = 16'h0000;
        ppu_cs_n     = 1'b1;
        ppu_WE       = 1'b0;
        ppu_reg_addr = 3'd0;
        ppu_data     = 8'h00;

        unique case (state_reg)
            ST_IDLE: begin
                // Bus and PPU port are released.
            end

            ST_HALT, ST_ALIGN: begin
                cpu_halt = 1'b1;
                dma_busy = 1'b1;
            end

            ST_READ: begin
                cpu_halt = 1'b1;
                dma_busy = 1'b1;
                dma_rd   = 1'b1;
                dma_addr = {page_reg, offset_reg};
            end

            ST_WRITE: begin
                cpu_halt     = 1'b1;
                dma_busy     = 1'b1;
                ppu_cs_n     = 1'b0;
                ppu_WE       = 1'b1;
                ppu_reg_addr = OAMDATA_REG;
                ppu_data     = data_lat_reg;
            end

            default: begin
                // Unreachable encodings leave everything released.
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_ctrl - self-checking bench for oam_dma_ctrl.
// A transfer pushes its expected read addresses and OAM bytes into queues;
// every dma_rd / ppu_WE cycle pops and compares against them.
// ---------------------------------------------------------------------------
module tb_oam_dma_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_in;
    logic        cpu_WE;
    logic        cpu_is_read;
    logic        cpu_halt;
    logic        dma_busy;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic [7:0]  mem_data_in;
    logic        ppu_cs_n;
    logic [2:0]  ppu_reg_addr;
    logic        ppu_WE;
    logic [7:0]  ppu_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] addr_q[$];
    logic [7:0]  data_q[$];

    // Bus phase as described for the design: cleared by reset, toggles
    // every clock.
    bit tb_phase;

    oam_dma_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_addr     (cpu_addr),
        .cpu_data_in  (cpu_data_in),
        .cpu_WE       (cpu_WE),
        .cpu_is_read  (cpu_is_read),
        .cpu_halt     (cpu_halt),
        .dma_busy     (dma_busy),
        .dma_addr     (dma_addr),
        .dma_rd       (dma_rd),
        .mem_data_in  (mem_data_in),
        .ppu_cs_n     (ppu_cs_n),
        .ppu_reg_addr (ppu_reg_addr),
        .ppu_WE       (ppu_WE),
        .ppu_data     (ppu_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) tb_phase <= 1'b0;
        else       tb_phase <= ~tb_phase;
    end

    // Memory image: page $02 holds i^$5A, other pages are further scrambled.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'h02);
    endfunction

    assign mem_data_in = mem_byte(dma_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one transfer of 'page'. 'wt' write cycles precede the dummy cycle.
    // want_align picks the trigger phase. inj_pair>=0 issues a second $4014
    // write at that pair; reset_pair>=0 resets at that pair instead.
    task automatic do_xfer(input logic [7:0] page, input int wt, input bit want_align,
                           input int inj_pair, input int reset_pair);
        int  halt_cnt;
        int  first_rd;
        int  reads;
        int  writes;
        int  cyc;
        bit  dummy_phase;
        bit  exp_align;
        bit  done;
        int  exp_halt;

        // Dummy-cycle phase = trigger-cycle phase toggled (wt+1) times.
        if ((tb_phase ^ ((wt + 1) % 2 == 1)) != !want_align) tick();

        for (int i = 0; i < 256; i++) begin
            addr_q.push_back({page, 8'(i)});
            data_q.push_back(mem_byte({page, 8'(i)}));
        end

        cpu_addr    = 16'h4014;
        cpu_data_in = page;
        cpu_WE      = 1'b1;
        cpu_is_read = (wt == 0);
        tick();
        cpu_WE      = 1'b0;
        cpu_addr    = 16'h0000;
        cpu_data_in = 8'h00;

        halt_cnt = 0; first_rd = -1; reads = 0; writes = 0;
        dummy_phase = 1'b0; done = 1'b0;
        for (cyc = 0; cyc < 1200; cyc++) begin
            cpu_WE      = 1'b0;
            cpu_addr    = 16'h0000;
            cpu_is_read = (cyc >= wt);
            if (cyc == wt) dummy_phase = tb_phase;
            if (!dma_busy) begin
                done = 1'b1;
                break;
            end
            if (cpu_halt) halt_cnt++;
            if (dma_rd) begin
                if (first_rd < 0) first_rd = cyc;
`ifdef OAM_DMA_ALIGN_EN
                check("rd_phase", {31'd0, tb_phase}, 32'd0);
`endif
                if (addr_q.size() == 0) check("rd_extra", 32'd1, 32'd0);
                else check("rd_addr", {16'd0, dma_addr}, {16'd0, addr_q.pop_front()});
                reads++;
            end
            if (ppu_WE) begin
                check("wr_cs_n", {31'd0, ppu_cs_n}, 32'd0);
                check("wr_reg", {29'd0, ppu_reg_addr}, 32'd4);
                if (data_q.size() == 0) check("wr_extra", 32'd1, 32'd0);
                else check("wr_data", {24'd0, ppu_data}, {24'd0, data_q.pop_front()});
                writes++;
            end
            if (dma_rd && reads == inj_pair + 1) begin
                cpu_addr    = 16'h4014;
                cpu_data_in = 8'h05;
                cpu_WE      = 1'b1;
            end
            if (dma_rd && reads == reset_pair + 1) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check("rst_halt", {31'd0, cpu_halt}, 32'd0);
                check("rst_cs_n", {31'd0, ppu_cs_n}, 32'd1);
                check("rst_busy", {31'd0, dma_busy}, 32'd0);
                $display("xfer page=%02h reset at pair %0d reads=%0d writes=%0d",
                         page, reset_pair, reads, writes);
                addr_q.delete();
                data_q.delete();
                return;
            end
            tick();
        end
        cpu_WE = 1'b0;

        check("xfer_done", {31'd0, done}, 32'd1);
`ifdef OAM_DMA_ALIGN_EN
        exp_align = (dummy_phase == 1'b0);
`else
        exp_align = 1'b0;
`endif
        exp_halt = wt + 1 + int'(exp_align) + 512;
        check("halt_len", halt_cnt, exp_halt);
        check("first_rd", first_rd, wt + 1 + int'(exp_align));
        check("n_writes", writes, 256);
        check("q_empty", addr_q.size() + data_q.size(), 0);
        $display("xfer page=%02h wait=%0d align=%0d halt=%0d writes=%0d first_rd=%0d",
                 page, wt, exp_align, halt_cnt, writes, first_rd);
        addr_q.delete();
        data_q.delete();
    endtask

    initial begin
        reset       = 1'b1;
        cpu_addr    = 16'h0000;
        cpu_data_in = 8'h00;
        cpu_WE      = 1'b0;
        cpu_is_read = 1'b1;
        repeat (3) tick();

        check("rst_cpu_halt", {31'd0, cpu_halt}, 32'd0);
        check("rst_dma_busy", {31'd0, dma_busy}, 32'd0);
        check("rst_dma_rd", {31'd0, dma_rd}, 32'd0);
        check("rst_dma_addr", {16'd0, dma_addr}, 32'd0);
        check("rst_ppu_cs_n", {31'd0, ppu_cs_n}, 32'd1);
        check("rst_ppu_WE", {31'd0, ppu_WE}, 32'd0);
        check("rst_ppu_reg", {29'd0, ppu_reg_addr}, 32'd0);
        check("rst_ppu_data", {24'd0, ppu_data}, 32'd0);
        reset = 1'b0;
        tick();

        // A write to a neighbouring address must not start a transfer.
        cpu_addr = 16'h4015; cpu_data_in = 8'h02; cpu_WE = 1'b1;
        tick();
        cpu_WE = 1'b0; cpu_addr = 16'h0000;
        tick();
        check("other_addr_busy", {31'd0, dma_busy}, 32'd0);
        check("other_addr_halt", {31'd0, cpu_halt}, 32'd0);
        $display("write $4015 ignored busy=%0d", dma_busy);

        do_xfer(8'h02, 0, 1'b0, -1, -1);   // no align needed
        tick();
        do_xfer(8'h02, 0, 1'b1, -1, -1);   // align needed (when enabled)
        tick();
        do_xfer(8'h02, 3, 1'b0, -1, -1);   // three write cycles before dummy
        tick();
        do_xfer(8'h02, 0, 1'b0, 40, -1);   // retrigger of $05 ignored
        tick();
        do_xfer(8'h02, 0, 1'b0, -1, 100);  // reset mid-transfer
        do_xfer(8'h03, 0, 1'b0, -1, -1);   // fresh transfer after reset
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
